// File: rtl/vrf_read_pkg.sv
// Shared field widths and the packed read-request record used by the VRF read arbiter.
package vrf_read_pkg;

  localparam int VS_W     = 5;
  localparam int OFFSET_W = 6;
  localparam int GROUP_W  = 4;
  localparam int SRC_W    = 4;
  localparam int INST_W   = 3;
  localparam int REQ_W    = VS_W + OFFSET_W + GROUP_W + SRC_W + INST_W;

  typedef struct packed {
    logic [VS_W-1:0]     vs;
    logic [OFFSET_W-1:0] offset;
    logic [GROUP_W-1:0]  group_index;
    logic [SRC_W-1:0]    read_source;
    logic [INST_W-1:0]   instruction_index;
  } vrf_read_req_t;

  // Increment modulo n; valid for any n, not only powers of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vrf_read_arbiter_if.sv
// Request/response bundle between the read-request generators (master) and the arbiter (slave).
interface vrf_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) ();
  import vrf_read_pkg::*;

  logic [NUM_REQ-1:0]          io_in_valid;
  logic [NUM_REQ-1:0]          io_in_ready;
  logic [VS_W*NUM_REQ-1:0]     io_in_bits_vs;
  logic [OFFSET_W*NUM_REQ-1:0] io_in_bits_offset;
  logic [GROUP_W*NUM_REQ-1:0]  io_in_bits_groupIndex;
  logic [SRC_W*NUM_REQ-1:0]    io_in_bits_readSource;
  logic [INST_W*NUM_REQ-1:0]   io_in_bits_instructionIndex;

  logic                        io_out_ready;
  logic                        io_out_valid;
  logic [VS_W-1:0]             io_out_bits_vs;
  logic [OFFSET_W-1:0]         io_out_bits_offset;
  logic [GROUP_W-1:0]          io_out_bits_groupIndex;
  logic [SRC_W-1:0]            io_out_bits_readSource;
  logic [INST_W-1:0]           io_out_bits_instructionIndex;
  logic [IDXW-1:0]             io_out_bits_source;
  logic                        io_busy;

  modport master (
    output io_in_valid, io_in_bits_vs, io_in_bits_offset, io_in_bits_groupIndex,
           io_in_bits_readSource, io_in_bits_instructionIndex, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits_vs, io_out_bits_offset,
           io_out_bits_groupIndex, io_out_bits_readSource, io_out_bits_instructionIndex,
           io_out_bits_source, io_busy
  );

  modport slave (
    input  io_in_valid, io_in_bits_vs, io_in_bits_offset, io_in_bits_groupIndex,
           io_in_bits_readSource, io_in_bits_instructionIndex, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits_vs, io_out_bits_offset,
           io_out_bits_groupIndex, io_out_bits_readSource, io_out_bits_instructionIndex,
           io_out_bits_source, io_busy
  );

endinterface

// File: rtl/vrf_read_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so ptr is bit 0, take the lowest set bit,
// then rotate the offset back into a requester index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [IDXW-1:0]    gnt_idx,
  output logic               gnt_valid
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  int                   off;
  int                   unrot;

  always_comb begin
    req_dbl   = {req, req};
    req_rot   = NUM_REQ'(req_dbl >> ptr);
    gnt_valid = |req_rot;
    off       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) off = k;
    end
    unrot = int'(ptr) + off;
    if (unrot >= NUM_REQ) unrot = unrot - NUM_REQ;
    gnt_idx = IDXW'(unrot);
  end

endmodule

// File: rtl/vrf_read_arbiter.sv
// Shares one VRF bank read port between NUM_REQ requesters with round-robin fairness and a
// single registered output entry that holds while the bank read stage stalls.
module vrf_read_arbiter
  import vrf_read_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input logic          clock,
  input logic          reset,
  vrf_read_arbiter_if.slave io
);

  vrf_read_req_t      req_in [NUM_REQ];
  logic [IDXW-1:0]    gnt_idx;
  logic               gnt_valid;
  logic               load;
  logic [NUM_REQ-1:0] in_ready;

  logic               out_valid_q, out_valid_d;
  vrf_read_req_t      out_req_q, out_req_d;
  logic [IDXW-1:0]    out_src_q, out_src_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_in[i].vs                = io.io_in_bits_vs[i*VS_W +: VS_W];
      req_in[i].offset            = io.io_in_bits_offset[i*OFFSET_W +: OFFSET_W];
      req_in[i].group_index       = io.io_in_bits_groupIndex[i*GROUP_W +: GROUP_W];
      req_in[i].read_source       = io.io_in_bits_readSource[i*SRC_W +: SRC_W];
      req_in[i].instruction_index = io.io_in_bits_instructionIndex[i*INST_W +: INST_W];
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_pick (
    .req       (io.io_in_valid),
    .ptr       (ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign load = !out_valid_q || io.io_out_ready;

  // Ready is additionally gated by reset so nothing handshakes while the block is held in reset.
  always_comb begin
    out_valid_d = out_valid_q;
    out_req_d   = out_req_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    in_ready    = '0;
    if (load) begin
      if (gnt_valid) begin
        out_valid_d = 1'b1;
        out_req_d   = req_in[gnt_idx];
        out_src_d   = gnt_idx;
        ptr_d       = IDXW'(wrap_inc(int'(gnt_idx), NUM_REQ));
      end else begin
        out_valid_d = 1'b0;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      in_ready[i] = load && gnt_valid && reset && (gnt_idx == IDXW'(i));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_req_q   <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_req_q   <= out_req_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign io.io_in_ready                  = in_ready;
  assign io.io_out_valid                 = out_valid_q;
  assign io.io_out_bits_vs               = out_req_q.vs;
  assign io.io_out_bits_offset           = out_req_q.offset;
  assign io.io_out_bits_groupIndex       = out_req_q.group_index;
  assign io.io_out_bits_readSource       = out_req_q.read_source;
  assign io.io_out_bits_instructionIndex = out_req_q.instruction_index;
  assign io.io_out_bits_source           = out_src_q;
  assign io.io_busy                      = out_valid_q | (|io.io_in_valid);

endmodule
